data_mem_responder: RTL and testbench

//  Handshaked data-memory responder: the slave end of the datapath's load/store port.

---
 rtl/data_mem_responder.sv | 144 ++++++++++++++
 tb/tb_data_mem_responder.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Handshaked load/store responder: accepts one request, waits LATENCY cycles,
// performs a little-endian byte/half/word access and returns a one-cycle response.
module data_mem_responder #(
  parameter int WORDS   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  output logic        rsp_valid,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int IW = $clog2(WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg;
  logic            we_reg;
  logic [1:0]      off_reg;
  logic [IW-1:0]   idx_reg;
  logic [31:0]     wdata_reg;
  logic [2:0]      f3_reg;
  logic [31:0]     word_reg;
  logic [31:0]     mem [WORDS];

  logic            accept, access, legal, wr_en;
  logic [3:0]      be;
  logic [31:0]     wlane;
  logic [31:0]     load_val;
  logic [7:0]      lane [4];
  logic [7:0]      sel_byte;
  logic [15:0]     sel_half;
  logic            addr_unused;

  // Address bits above the word index wrap away.
  assign addr_unused = ^addr[31:IW+2];

  assign accept = (state_reg == IDLE) && req_valid;
  assign access = (state_reg == WAIT) && (cnt_reg == '0);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // FSM: next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_valid) state_next = WAIT;
      WAIT:    if (cnt_reg == '0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    req_ready = (state_reg == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst)                                   cnt_reg <= '0;
    else if (accept)                           cnt_reg <= CW'(LATENCY - 1);
    else if (state_reg == WAIT && cnt_reg != '0) cnt_reg <= cnt_reg - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_reg    <= we;
      off_reg   <= addr[1:0];
      idx_reg   <= addr[IW+1:2];
      wdata_reg <= wdata;
      f3_reg    <= funct3;
    end
  end

  // Storage: read is registered at the accept edge; any earlier store has
  // already completed, since a new accept always follows the previous access.
  always_ff @(posedge clk) begin
    if (accept) word_reg <= mem[addr[IW+1:2]];
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx_reg][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      assign lane[gi] = word_reg[8*gi +: 8];
      assign be[gi] = (f3_reg[1:0] == 2'b10) ||
                      (f3_reg[1:0] == 2'b01 && off_reg[1] == LANE[1]) ||
                      (f3_reg[1:0] == 2'b00 && off_reg == LANE);
      assign wlane[8*gi +: 8] = (f3_reg[1:0] == 2'b10) ? wdata_reg[8*gi +: 8] :
                                (f3_reg[1:0] == 2'b01) ? wdata_reg[8*(gi%2) +: 8] :
                                                         wdata_reg[7:0];
    end
  endgenerate

  assign sel_byte = lane[off_reg];
  assign sel_half = off_reg[1] ? word_reg[31:16] : word_reg[15:0];

  always_comb begin
    legal    = 1'b0;
    load_val = '0;
    case (f3_reg)
      3'b000: begin legal = 1'b1;                   load_val = {{24{sel_byte[7]}}, sel_byte}; end
      3'b001: begin legal = ~off_reg[0];            load_val = {{16{sel_half[15]}}, sel_half}; end
      3'b010: begin legal = (off_reg == 2'b00);     load_val = word_reg; end
      3'b100: begin legal = ~we_reg;                load_val = {24'b0, sel_byte}; end
      3'b101: begin legal = ~we_reg & ~off_reg[0];  load_val = {16'b0, sel_half}; end
      default: legal = 1'b0;
    endcase
  end

  assign wr_en = access && legal && we_reg && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rdata     <= '0;
      err       <= 1'b0;
    end else begin
      rsp_valid <= access;
      if (access) begin
        err   <= ~legal;
        rdata <= (legal && !we_reg) ? load_val : 32'b0;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised and directed bench for data_mem_responder against a byte-level
// behavioural memory model.
module tb_data_mem_responder;

  localparam int WORDS   = 1024;
  localparam int LATENCY = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [2:0]  funct3 = '0;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] ref_mem [WORDS];

  data_mem_responder #(.WORDS(WORDS), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .we(we), .addr(addr), .wdata(wdata), .funct3(funct3),
    .rsp_valid(rsp_valid), .rdata(rdata), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: access size from funct3, byte lanes handled one at a time.
  function automatic void model(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic [2:0] f, output logic [31:0] rd, output logic e);
    int size, off, idx;
    logic [31:0] word, mask;
    size = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
    off  = int'(a % 4);
    idx  = int'((a / 4) % WORDS);
    e  = (f == 3'd3) || (f == 3'd6) || (f == 3'd7) || (w && f >= 3'd4) || (off % size != 0);
    rd = '0;
    if (e) return;
    if (w) begin
      for (int b = off; b < off + size; b++)
        ref_mem[idx][8*b +: 8] = d[8*(b-off) +: 8];
    end else begin
      word = ref_mem[idx] >> (8*off);
      if (size < 4) begin
        mask = (32'h1 << (8*size)) - 32'h1;
        word = word & mask;
        if (f < 3'd4 && word[8*size-1]) word = word | ~mask;
      end
      rd = word;
    end
  endfunction

  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [2:0] f, output logic [31:0] got_rd, output logic got_e);
    logic [31:0] exp_rd;
    logic        exp_e;
    model(w, a, d, f, exp_rd, exp_e);
    check("ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; we = w; addr = a; wdata = d; funct3 = f;
    for (int k = 1; k <= LATENCY + 1; k++) begin
      @(negedge clk);
      // Junk on the inputs while busy must be ignored.
      req_valid = 1'($urandom); we = 1'($urandom); addr = $urandom;
      wdata = $urandom; funct3 = 3'($urandom);
      check("ready_busy", 32'(req_ready), 32'd0);
      check("rsp_valid_timing", 32'(rsp_valid), 32'(k == LATENCY + 1));
    end
    check("rdata", rdata, exp_rd);
    check("err", 32'(err), 32'(exp_e));
    got_rd = rdata;
    got_e  = err;
    @(negedge clk);
    req_valid = 1'b0;
    check("ready_after", 32'(req_ready), 32'd1);
    check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    check("rdata_hold", rdata, exp_rd);
    check("err_hold", 32'(err), 32'(exp_e));
    $display("txn we=%0d f3=%0d addr=%h wdata=%h -> rdata=%h err=%0d", w, f, a, d, got_rd, got_e);
  endtask

  initial begin
    logic [31:0] r;
    logic        e;
    logic [31:0] a;

    repeat (3) @(negedge clk);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rdata", rdata, 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_ready", 32'(req_ready), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) txn(1'b1, 32'(i * 4), $urandom, 3'b010, r, e);

    txn(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, r, e);
    check("sw_rdata_zero", r, 32'd0);
    txn(1'b0, 32'h13, 32'h0, 3'b000, r, e); check("lb_13", r, 32'hFFFFFFDE);
    txn(1'b0, 32'h13, 32'h0, 3'b100, r, e); check("lbu_13", r, 32'h000000DE);
    txn(1'b0, 32'h12, 32'h0, 3'b001, r, e); check("lh_12", r, 32'hFFFFDEAD);
    txn(1'b0, 32'h10, 32'h0, 3'b101, r, e); check("lhu_10", r, 32'h0000BEEF);

    txn(1'b1, 32'h11, 32'h55, 3'b000, r, e);
    txn(1'b0, 32'h10, 32'h0, 3'b010, r, e); check("lw_after_sb", r, 32'hDEAD55EF);

    txn(1'b0, 32'h12, 32'h0, 3'b010, r, e);        check("lw_mis_err", 32'(e), 32'd1);
    txn(1'b1, 32'h11, 32'hFFFF, 3'b001, r, e);     check("sh_mis_err", 32'(e), 32'd1);
    txn(1'b1, 32'h10, 32'h12345678, 3'b100, r, e); check("sw_f100_err", 32'(e), 32'd1);
    txn(1'b0, 32'h10, 32'h0, 3'b010, r, e);        check("lw_untouched", r, 32'hDEAD55EF);

    txn(1'b1, 32'h1010, 32'h1, 3'b010, r, e);
    txn(1'b0, 32'h10, 32'h0, 3'b010, r, e); check("lw_wrap", r, 32'h1);

    // Reset coinciding with the access edge of a store.
    txn(1'b1, 32'h20, 32'h12345678, 3'b010, r, e);
    req_valid = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h7; funct3 = 3'b010;
    for (int k = 1; k <= LATENCY; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      check("rst_pre_rsp", 32'(rsp_valid), 32'd0);
      if (k == LATENCY) begin
        rst = 1'b1; req_valid = 1'b1; wdata = 32'hBAD;
      end
    end
    repeat (2) begin
      @(negedge clk);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_ready", 32'(req_ready), 32'd1);
      check("rst_rdata", rdata, 32'd0);
      check("rst_err", 32'(err), 32'd0);
    end
    rst = 1'b0; req_valid = 1'b0;
    for (int k = 0; k < LATENCY + 2; k++) begin
      @(negedge clk);
      check("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
      check("post_rst_ready", 32'(req_ready), 32'd1);
    end
    txn(1'b0, 32'h20, 32'h0, 3'b010, r, e); check("lw_after_rst", r, 32'h12345678);

    for (int i = 0; i < 200; i++) begin
      a = $urandom;
      a[11:6] = 6'd0;
      txn(1'($urandom), a, $urandom, 3'($urandom), r, e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
